rst_btn_conditioner: RTL and testbench

- Sits directly upstream of the tinyQV core reset input on the Nano20K board.
- Synchronises and debounces the two user buttons and gates reset on PLL lock.
- Drives a clean, stretched, active-low core reset, replacing the raw "either button pressed" combinational reset.
- Also exports debounced button levels, press pulses and a saturating reset counter for LED/status use.

---
 rtl/rst_btn_pkg.sv | 22 ++
 rtl/rst_btn_conditioner_debounce.sv | 60 ++++++
 rtl/rst_btn_conditioner.sv | 110 +++++++++++
 tb/tb_rst_btn_conditioner.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_btn_pkg.sv
// Shared types and default sizing for the button/reset conditioner.
// Width helpers keep counter widths legal for the smallest parameter values.
package rst_btn_pkg;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 640000;
    localparam int unsigned RST_HOLD_CYCLES_DEF = 64;

    localparam int unsigned RST_COUNT_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_e;

    // $clog2 of 1 is 0, which is not a usable vector width
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rst_btn_conditioner_debounce.sv
// One button channel: synchroniser chain, debounce counter, level and press pulse.
// The level flips only after DEBOUNCE_CYCLES consecutive differing synchronised samples.
module btn_debounce
    import rst_btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   btn_sync;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (btn_sync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = btn_sync;
            press_d = btn_sync;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: rtl/rst_btn_conditioner.sv
// Core reset conditioner: debounced buttons and PLL lock gate a stretched active-low reset.
// state     | meaning
// WAIT_LOCK | PLL not locked, core held in reset
// HOLD      | locked, stretching reset until buttons released for RST_HOLD_CYCLES
// RUN       | core out of reset
module rst_btn_conditioner
    import rst_btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_lock,
    input  logic [1:0]             btn_raw,
    output logic                   core_rst_n,
    output logic [1:0]             btn_level,
    output logic [1:0]             btn_press,
    output logic [RST_COUNT_W-1:0] rst_count
);

    localparam int unsigned   HW        = cnt_width(RST_HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

    for (genvar i = 0; i < 2; i++) begin : g_btn
        btn_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw  (btn_raw[i]),
            .btn_level(btn_level[i]),
            .btn_press(btn_press[i])
        );
    end

    logic [SYNC_STAGES-1:0] lock_q, lock_d;
    state_e                 state_q, state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   core_q, core_d;
    logic [RST_COUNT_W-1:0] count_q, count_d;
    logic                   lock_sync;
    logic                   req;

    assign lock_sync = lock_q[SYNC_STAGES-1];
    assign req       = |btn_level;

    always_comb begin
        lock_d  = {lock_q[SYNC_STAGES-2:0], pll_lock};
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;
        // lock loss outranks any button request in the same cycle
        if (!lock_sync) begin
            state_d = WAIT_LOCK;
            hold_d  = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
                HOLD: begin
                    if (req) begin
                        hold_d = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        state_d = RUN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                RUN: begin
                    if (req) begin
                        state_d = HOLD;
                        hold_d  = '0;
                        if (count_q != '1) count_d = count_q + 1'b1;
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                end
            endcase
        end
        core_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q  <= '0;
            state_q <= WAIT_LOCK;
            hold_q  <= '0;
            core_q  <= 1'b0;
            count_q <= '0;
        end else begin
            lock_q  <= lock_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            core_q  <= core_d;
            count_q <= count_d;
        end
    end

    assign core_rst_n = core_q;
    assign rst_count  = count_q;

endmodule

// File: tb/tb_rst_btn_conditioner.sv
// Directed bench for rst_btn_conditioner with a cycle-level behavioural model
// checked every cycle, plus hand-computed timing expectations.
module tb_rst_btn_conditioner;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int HOLDC = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       pll_lock = 1'b0;
    logic [1:0] btn_raw  = 2'b00;
    logic       core_rst_n;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [7:0] rst_count;

    int vectors     = 0;
    int miscompares = 0;
    int press_total = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    rst_btn_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .RST_HOLD_CYCLES(HOLDC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .btn_raw   (btn_raw),
        .core_rst_n(core_rst_n),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .rst_count (rst_count)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // Model: inputs delayed by SYNC edges, a level flips when the last DEB
    // delayed samples all disagree with it, reset releases after lock has been
    // seen for HOLDC+1 edges and buttons idle for HOLDC edges.
    bit [1:0] m_level = '0;
    bit [1:0] m_press = '0;
    bit       m_core  = 1'b0;
    int       m_count = 0;
    bit [1:0] btn_pipe[$];
    bit       lock_pipe[$];
    bit [1:0] seen_win[$];
    int       lock_run = 0;
    int       idle_run = 0;

    always @(posedge clk) begin : model
        bit [1:0] seen;
        bit [1:0] nl;
        bit       lk;
        bit       req;
        bit       all_diff;
        if (!rst_n) begin
            m_level   = '0;
            m_press   = '0;
            m_core    = 1'b0;
            m_count   = 0;
            btn_pipe  = {};
            lock_pipe = {};
            for (int k = 0; k < SYNC; k++) begin
                btn_pipe.push_back(2'b00);
                lock_pipe.push_back(1'b0);
            end
            seen_win = {};
            lock_run = 0;
            idle_run = 0;
        end else begin
            seen = btn_pipe.pop_front();
            btn_pipe.push_back(btn_raw);
            lk = lock_pipe.pop_front();
            lock_pipe.push_back(pll_lock);
            seen_win.push_back(seen);
            if (seen_win.size() > DEB) void'(seen_win.pop_front());
            req = |m_level;
            nl  = m_level;
            for (int b = 0; b < 2; b++) begin
                if (seen_win.size() == DEB) begin
                    all_diff = 1'b1;
                    foreach (seen_win[k]) if (seen_win[k][b] == m_level[b]) all_diff = 1'b0;
                    if (all_diff) nl[b] = ~m_level[b];
                end
            end
            lock_run = lk ? lock_run + 1 : 0;
            idle_run = (lk && !req) ? idle_run + 1 : 0;
            if (m_core && lk && req && m_count < 255) m_count++;
            m_core  = lk && !req && (m_core || (lock_run >= HOLDC + 1 && idle_run >= HOLDC));
            m_press = nl & ~m_level;
            m_level = nl;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("core_rst_n", core_rst_n, m_core);
            check("btn_level", btn_level, m_level);
            check("btn_press", btn_press, m_press);
            check("rst_count", rst_count, m_count[7:0]);
            if (btn_press[0] === 1'b1) press_total++;
        end
    end

    task automatic startup_seq(input string tag);
        repeat (10) @(negedge clk);
        check({tag, "_core_low_e10"}, core_rst_n, 1'b0);
        @(negedge clk);
        check({tag, "_core_high_e11"}, core_rst_n, 1'b1);
        check({tag, "_count_zero"}, rst_count, 8'd0);
    endtask

    initial begin
        // 1: reset and power-up sequence
        rst_n    = 1'b0;
        pll_lock = 1'b1;
        btn_raw  = 2'b00;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("t1_reset_core", core_rst_n, 1'b0);
        check("t1_reset_level", btn_level, 2'b00);
        check("t1_reset_count", rst_count, 8'd0);
        rst_n = 1'b1;
        startup_seq("t1");

        // 2: single press of s1
        repeat (3) @(negedge clk);
        btn_raw = 2'b01;
        repeat (5) @(negedge clk);
        check("t2_level_before_e6", btn_level, 2'b00);
        @(negedge clk);
        check("t2_level_e6", btn_level, 2'b01);
        check("t2_press_e6", btn_press, 2'b01);
        @(negedge clk);
        check("t2_press_gone", btn_press, 2'b00);
        check("t2_core_low", core_rst_n, 1'b0);
        check("t2_count_one", rst_count, 8'd1);
        repeat (13) @(negedge clk);
        btn_raw = 2'b00;
        repeat (6) @(negedge clk);
        check("t2_level_released", btn_level, 2'b00);
        repeat (7) @(negedge clk);
        check("t2_core_still_low", core_rst_n, 1'b0);
        @(negedge clk);
        check("t2_core_back_high", core_rst_n, 1'b1);

        // 3: short glitches on s2 never reach the level
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            btn_raw = 2'b10;
            repeat (3) @(negedge clk);
            btn_raw = 2'b00;
            repeat (3) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        check("t3_level", btn_level, 2'b00);
        check("t3_core", core_rst_n, 1'b1);

        // 4: one-cycle lock drop
        pll_lock = 1'b0;
        @(negedge clk);
        check("t4_core_e1", core_rst_n, 1'b1);
        pll_lock = 1'b1;
        @(negedge clk);
        check("t4_core_e2", core_rst_n, 1'b1);
        @(negedge clk);
        check("t4_core_e3", core_rst_n, 1'b0);
        repeat (8) @(negedge clk);
        check("t4_core_e11", core_rst_n, 1'b0);
        @(negedge clk);
        check("t4_core_e12", core_rst_n, 1'b1);
        check("t4_count", rst_count, 8'd1);

        // 5: 300 presses saturate the counter
        press_total = 0;
        for (int i = 0; i < 300; i++) begin
            btn_raw = 2'b01;
            repeat (10) @(negedge clk);
            btn_raw = 2'b00;
            repeat (30) @(negedge clk);
        end
        check("t5_count_sat", rst_count, 8'd255);
        check("t5_press_pulses", press_total, 300);
        check("t5_core", core_rst_n, 1'b1);

        // 6: block reset in HOLD at hold count 5
        btn_raw = 2'b01;
        repeat (10) @(negedge clk);
        btn_raw = 2'b00;
        repeat (11) @(negedge clk);
        check("t6_core_in_hold", core_rst_n, 1'b0);
        check("t6_level_in_hold", btn_level, 2'b00);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_reset_core", core_rst_n, 1'b0);
        check("t6_reset_level", btn_level, 2'b00);
        check("t6_reset_press", btn_press, 2'b00);
        check("t6_reset_count", rst_count, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        startup_seq("t6");

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
